// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared types and constants for the pipeline hazard logic:
//                controller state encoding, forwarding select codes, the
//                load result-select code and the forwarding match helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    localparam logic [1:0] FWD_RF          = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Forward select for one EX operand. MEM is younger than WB, so it wins;
    // x0 is hard-wired zero and is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       we_m,
        input logic [4:0] rd_m,
        input logic       we_w,
        input logic [4:0] rd_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end
        if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundle between the pipeline datapath (master) and the hazard
//                controller (slave).
//                Pipeline -> controller : register IDs of D/E/M/W stages,
//                  ResultSrcE, PCSrcE, RegWriteM/W, MemReqM, dmem_ready.
//                Controller -> pipeline : StallF..StallW, FlushD/FlushE,
//                  ForwardAE/BE, mem_timeout, stall_cycles.
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           Rs1D, Rs2D;
    logic [4:0]           Rs1E, Rs2E, RdE;
    logic [1:0]           ResultSrcE;
    logic                 PCSrcE;
    logic [4:0]           RdM, RdW;
    logic                 RegWriteM, RegWriteW;
    logic                 MemReqM;
    logic                 dmem_ready;
    logic                 StallF, StallD, StallE, StallM, StallW;
    logic                 FlushD, FlushE;
    logic [1:0]           ForwardAE, ForwardBE;
    logic                 mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        output RdM, RdW, RegWriteM, RegWriteW, MemReqM, dmem_ready,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        input  ForwardAE, ForwardBE, mem_timeout, stall_cycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        input  RdM, RdW, RegWriteM, RegWriteW, MemReqM, dmem_ready,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        output ForwardAE, ForwardBE, mem_timeout, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forward_unit
//  Description : Combinational EX-stage operand forwarding selects.
//                i_rs1e/i_rs2e : EX source registers
//                i_rdm/i_regwrite_m, i_rdw/i_regwrite_w : MEM/WB writers
//                o_fwd_a/o_fwd_b : 00 regfile, 10 from MEM, 01 from WB
//  Revision    : 1.0  initial release
// ============================================================================
module forward_unit
    import pipeline_pkg::*;
(
    input  wire logic [4:0] i_rs1e,
    input  wire logic [4:0] i_rs2e,
    input  wire logic [4:0] i_rdm,
    input  wire logic       i_regwrite_m,
    input  wire logic [4:0] i_rdw,
    input  wire logic       i_regwrite_w,
    output logic      [1:0] o_fwd_a,
    output logic      [1:0] o_fwd_b
);
    assign o_fwd_a = fwd_sel(i_rs1e, i_regwrite_m, i_rdm, i_regwrite_w, i_rdw);
    assign o_fwd_b = fwd_sel(i_rs2e, i_regwrite_m, i_rdm, i_regwrite_w, i_rdw);
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard and sequencing controller. Generates stalls,
//                flushes and forwarding selects; sequences the post-reset
//                flush (INIT) and data-memory wait states (MEM_WAIT).
//                clk, reset : clock, synchronous active-high reset
//                bus        : hazard_ctrl_if slave (all pipeline signals)
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int INIT_FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT       = 64,
    parameter int CNT_WIDTH         = 32
) (
    input  wire logic   clk,
    input  wire logic   reset,
    hazard_ctrl_if.slave bus
);
    localparam int INIT_W = (INIT_FLUSH_CYCLES > 1) ? $clog2(INIT_FLUSH_CYCLES) : 1;
    localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [INIT_W-1:0] c_init_last = INIT_W'(INIT_FLUSH_CYCLES - 1);
    localparam logic [TMO_W-1:0]  c_tmo_max   = TMO_W'(MEM_TIMEOUT);

    hazard_state_t        r_state, w_next;
    logic [INIT_W-1:0]    r_init_cnt;
    logic [TMO_W-1:0]     r_tmo_cnt;
    logic [TMO_W-1:0]     w_tmo_next;
    logic                 r_mem_timeout;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_rule_flush_d, w_rule_flush_e, w_rule_stall_fd;
    logic w_stall_fd, w_stall_emw, w_flush_d, w_flush_e;
    logic w_tmo_load, w_tmo_inc;
    logic [1:0] w_fwd_a, w_fwd_b;

    assign w_load_use = (bus.ResultSrcE == RESULT_SRC_LOAD) && (bus.RdE != 5'd0) &&
                        ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    // Branch/load-use rules shared by RUN and the MEM_WAIT release cycle.
    // A taken branch squashes the dependent instruction, so no stall is needed.
    assign w_rule_flush_d  = bus.PCSrcE;
    assign w_rule_flush_e  = bus.PCSrcE | w_load_use;
    assign w_rule_stall_fd = !bus.PCSrcE && w_load_use;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_stall_fd  = 1'b0;
        w_stall_emw = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        w_tmo_load  = 1'b0;
        w_tmo_inc   = 1'b0;
        case (r_state)
            INIT: begin
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
                if (r_init_cnt == c_init_last) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (bus.MemReqM && !bus.dmem_ready) begin
                    w_stall_fd  = 1'b1;
                    w_stall_emw = 1'b1;
                    w_tmo_load  = 1'b1;
                    w_next      = MEM_WAIT;
                end else begin
                    w_stall_fd = w_rule_stall_fd;
                    w_flush_d  = w_rule_flush_d;
                    w_flush_e  = w_rule_flush_e;
                end
            end
            MEM_WAIT: begin
                // Release on completion or on timeout; either way the
                // pipeline advances this cycle, so the normal rules apply.
                if (bus.dmem_ready || (r_tmo_cnt == c_tmo_max)) begin
                    w_stall_fd = w_rule_stall_fd;
                    w_flush_d  = w_rule_flush_d;
                    w_flush_e  = w_rule_flush_e;
                    w_next     = RUN;
                end else begin
                    w_stall_fd  = 1'b1;
                    w_stall_emw = 1'b1;
                    w_tmo_inc   = 1'b1;
                end
            end
            default: begin
                w_next = INIT;
            end
        endcase
    end

    assign w_tmo_next = w_tmo_load ? TMO_W'(1) : (r_tmo_cnt + TMO_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_cnt    <= '0;
            r_tmo_cnt     <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            if ((r_state == INIT) && (r_init_cnt != c_init_last)) begin
                r_init_cnt <= r_init_cnt + INIT_W'(1);
            end
            if (w_tmo_load || w_tmo_inc) begin
                r_tmo_cnt <= w_tmo_next;
                // Flag goes up as the counter reaches the limit, so it is
                // already visible in the cycle the stalls release.
                if (w_tmo_next == c_tmo_max) begin
                    r_mem_timeout <= 1'b1;
                end
            end
            if (w_stall_fd && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    forward_unit u_forward_unit (
        .i_rs1e       (bus.Rs1E),
        .i_rs2e       (bus.Rs2E),
        .i_rdm        (bus.RdM),
        .i_regwrite_m (bus.RegWriteM),
        .i_rdw        (bus.RdW),
        .i_regwrite_w (bus.RegWriteW),
        .o_fwd_a      (w_fwd_a),
        .o_fwd_b      (w_fwd_b)
    );

    assign bus.StallF       = w_stall_fd;
    assign bus.StallD       = w_stall_fd;
    assign bus.StallE       = w_stall_emw;
    assign bus.StallM       = w_stall_emw;
    assign bus.StallW       = w_stall_emw;
    assign bus.FlushD       = w_flush_d;
    assign bus.FlushE       = w_flush_e;
    assign bus.ForwardAE    = (r_state == INIT) ? FWD_RF : w_fwd_a;
    assign bus.ForwardBE    = (r_state == INIT) ? FWD_RF : w_fwd_b;
    assign bus.mem_timeout  = r_mem_timeout;
    assign bus.stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: table of single-cycle
//                RUN vectors plus directed init, wait, timeout and reset
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam int CNT_WIDTH = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   exp_stalls;

    hazard_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    hazard_ctrl #(
        .INIT_FLUSH_CYCLES (2),
        .MEM_TIMEOUT       (8),
        .CNT_WIDTH         (CNT_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       pcsrc, rwm, rww;
        logic [4:0] exp_st;   // {F,D,E,M,W}
        logic [1:0] exp_fl;   // {D,E}
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    localparam int NV = 11;
    vec_t tv [NV];

    function automatic vec_t mkv(
        input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
        input logic [1:0] rsrc,
        input logic       pcsrc, rwm, rww,
        input logic [4:0] exp_st,
        input logic [1:0] exp_fl, exp_fa, exp_fb
    );
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rsrc = rsrc;
        v.pcsrc = pcsrc; v.rwm = rwm; v.rww = rww;
        v.exp_st = exp_st; v.exp_fl = exp_fl; v.exp_fa = exp_fa; v.exp_fb = exp_fb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctrl(input string name, input logic [4:0] st, input logic [1:0] fl);
        chk({name, ".stalls"}, 64'({bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.StallW}), 64'(st));
        chk({name, ".flushes"}, 64'({bus.FlushD, bus.FlushE}), 64'(fl));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Rs1D = '0; bus.Rs2D = '0; bus.Rs1E = '0; bus.Rs2E = '0;
        bus.RdE = '0; bus.RdM = '0; bus.RdW = '0; bus.ResultSrcE = '0;
        bus.PCSrcE = 1'b0; bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
        bus.MemReqM = 1'b0; bus.dmem_ready = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_stalls = 0;

        //          rs1d rs2d rs1e rs2e rde rdm rdw rsrc  pc rwm rww  stalls    flush  fa     fb
        tv[0]  = mkv(0,  0,   0,   0,   0,  0,  0,  2'b00, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00);
        tv[1]  = mkv(0,  0,   5,   0,   0,  5,  5,  2'b00, 0, 1, 1, 5'b00000, 2'b00, 2'b10, 2'b00);
        tv[2]  = mkv(0,  0,   0,   0,   0,  0,  0,  2'b00, 0, 1, 1, 5'b00000, 2'b00, 2'b00, 2'b00);
        tv[3]  = mkv(0,  0,   5,   5,   0,  5,  5,  2'b00, 0, 0, 1, 5'b00000, 2'b00, 2'b01, 2'b01);
        tv[4]  = mkv(0,  0,   4,   3,   0,  3,  4,  2'b00, 0, 1, 1, 5'b00000, 2'b00, 2'b01, 2'b10);
        tv[5]  = mkv(0,  7,   0,   0,   7,  0,  0,  2'b01, 0, 0, 0, 5'b11000, 2'b01, 2'b00, 2'b00);
        tv[6]  = mkv(0,  7,   0,   0,   7,  0,  0,  2'b01, 1, 0, 0, 5'b00000, 2'b11, 2'b00, 2'b00);
        tv[7]  = mkv(0,  0,   0,   0,   0,  0,  0,  2'b01, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00);
        tv[8]  = mkv(7,  0,   0,   0,   7,  0,  0,  2'b00, 0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00);
        tv[9]  = mkv(9,  0,   0,   0,   9,  0,  0,  2'b01, 0, 0, 0, 5'b11000, 2'b01, 2'b00, 2'b00);
        tv[10] = mkv(0,  0,   0,   0,   0,  0,  0,  2'b00, 1, 0, 0, 5'b00000, 2'b11, 2'b00, 2'b00);

        // ---- reset and post-reset flush ----
        clear_inputs();
        reset = 1'b1;
        bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_ctrl("reset", 5'b00000, 2'b11);
        chk("reset.fwdA_forced", 64'(bus.ForwardAE), 64'(2'b00));
        chk("reset.stall_cycles", 64'(bus.stall_cycles), 64'd0);
        chk("reset.mem_timeout", 64'(bus.mem_timeout), 64'd0);
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk_ctrl("init0", 5'b00000, 2'b11);
        next_cycle();
        @(negedge clk);
        chk_ctrl("init1", 5'b00000, 2'b11);
        next_cycle();
        @(negedge clk);
        chk_ctrl("run0", 5'b00000, 2'b00);

        // ---- table of single-cycle RUN vectors ----
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            bus.Rs1D = tv[i].rs1d; bus.Rs2D = tv[i].rs2d;
            bus.Rs1E = tv[i].rs1e; bus.Rs2E = tv[i].rs2e;
            bus.RdE = tv[i].rde; bus.RdM = tv[i].rdm; bus.RdW = tv[i].rdw;
            bus.ResultSrcE = tv[i].rsrc; bus.PCSrcE = tv[i].pcsrc;
            bus.RegWriteM = tv[i].rwm; bus.RegWriteW = tv[i].rww;
            @(negedge clk);
            chk_ctrl($sformatf("vec%0d", i), tv[i].exp_st, tv[i].exp_fl);
            chk($sformatf("vec%0d.fwdA", i), 64'(bus.ForwardAE), 64'(tv[i].exp_fa));
            chk($sformatf("vec%0d.fwdB", i), 64'(bus.ForwardBE), 64'(tv[i].exp_fb));
            if (tv[i].exp_st[4]) exp_stalls++;
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("table.stall_cycles", 64'(bus.stall_cycles), 64'(exp_stalls));

        // ---- 4-cycle memory wait with a branch arriving mid-wait ----
        next_cycle();
        bus.MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            if (i == 1) bus.PCSrcE = 1'b1;
            @(negedge clk);
            chk_ctrl($sformatf("wait%0d", i), 5'b11111, 2'b00);
            exp_stalls++;
        end
        next_cycle();
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        chk_ctrl("wait_ready", 5'b00000, 2'b11);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk_ctrl("after_wait", 5'b00000, 2'b00);
        chk("wait.stall_cycles", 64'(bus.stall_cycles), 64'(exp_stalls));

        // ---- timeout: dmem_ready never asserts ----
        next_cycle();
        bus.MemReqM = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            chk_ctrl($sformatf("tmo%0d", i), 5'b11111, 2'b00);
            chk($sformatf("tmo%0d.flag", i), 64'(bus.mem_timeout), 64'd0);
            exp_stalls++;
        end
        next_cycle();
        @(negedge clk);
        chk_ctrl("tmo_release", 5'b00000, 2'b00);
        chk("tmo_release.flag", 64'(bus.mem_timeout), 64'd1);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk_ctrl("tmo_run", 5'b00000, 2'b00);
        chk("tmo.stall_cycles", 64'(bus.stall_cycles), 64'(exp_stalls));
        repeat (3) next_cycle();
        @(negedge clk);
        chk("tmo.sticky", 64'(bus.mem_timeout), 64'd1);

        // ---- reset in the 2nd cycle of MEM_WAIT ----
        next_cycle();
        bus.MemReqM = 1'b1;
        @(negedge clk);
        chk_ctrl("rstw_run", 5'b11111, 2'b00);
        next_cycle();
        @(negedge clk);
        chk_ctrl("rstw_wait1", 5'b11111, 2'b00);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        chk_ctrl("rstw_init", 5'b00000, 2'b11);
        chk("rstw.mem_timeout", 64'(bus.mem_timeout), 64'd0);
        chk("rstw.stall_cycles", 64'(bus.stall_cycles), 64'd0);
        next_cycle();
        @(negedge clk);
        chk_ctrl("rstw_init1", 5'b00000, 2'b11);
        next_cycle();
        @(negedge clk);
        chk_ctrl("rstw_run2", 5'b00000, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
